// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: op encoding, size codes, FSM states
// and the lane/strobe helpers used on both the store and load paths.
package mem_pkg;

  // Field layout of the 4-bit access-type code coming from decode.
  typedef struct packed {
    logic       store;
    logic       zext;
    logic [1:0] size;
  } mem_op_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] STRB_NONE = 4'h0;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'hF;

  // Size code 3 has no meaning; it behaves as a word access everywhere.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SZ_W : size;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_H:    bad = lo[0];
      SZ_W:    bad = |lo;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Low address bits that actually select a lane once alignment is forced.
  function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lo);
    logic [1:0] lane;
    case (size)
      SZ_H:    lane = {lo[1], 1'b0};
      SZ_W:    lane = 2'b00;
      default: lane = lo;
    endcase
    return lane;
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] strb;
    case (size)
      SZ_B:    strb = STRB_B << lane;
      SZ_H:    strb = STRB_H << {lane[1], 1'b0};
      default: strb = STRB_W;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] data;
    case (size)
      SZ_B:    data = {4{wdata[7:0]}};
      SZ_H:    data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data SRAM bus of the load/store unit: request channel plus addr_ok/data_ok handshake.
interface mem_access_unit_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a 32-bit read word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] data
);

  logic [7:0]  byte_lane [4];
  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    b_sel = byte_lane[addr_lo];
    h_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data  = rdata;
    case (size)
      SZ_B:    data = zext ? {24'b0, b_sel} : {{24{b_sel[7]}}, b_sel};
      SZ_H:    data = zext ? {16'b0, h_sel} : {{16{h_sel[15]}}, h_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: one request at a time, SRAM req/addr_ok/data_ok
// handshake, aligned/extended load data or store completion back to WB.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ALE_CHECK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_ale,
  mem_access_unit_if.master data_sram
);

  state_t      state_reg, state_next;
  mem_op_t     op_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        ale_reg;

  mem_op_t     op_in;
  logic        in_misaligned;
  logic [1:0]  size_cur;
  logic [1:0]  lane_lo;
  logic [31:0] load_data;

  assign op_in         = mem_op_t'(req_op);
  assign in_misaligned = (ALE_CHECK != 0) && is_misaligned(norm_size(op_in.size), req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid)          state_next = in_misaligned ? RESP : REQ;
      REQ:     if (data_sram.addr_ok)  state_next = WAIT;
      // data_ok is only meaningful here; the SRAM never raises it alongside addr_ok.
      WAIT:    if (data_sram.data_ok)  state_next = RESP;
      RESP:    if (resp_ready)         state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      ale_reg   <= 1'b0;
    end else begin
      if (state_reg == IDLE && req_valid) begin
        op_reg    <= op_in;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        rdata_reg <= '0;
        ale_reg   <= in_misaligned;
      end
      if (state_reg == WAIT && data_sram.data_ok) begin
        rdata_reg <= op_reg.store ? 32'd0 : load_data;
      end
    end
  end

  // With the alignment check off, misaligned low bits simply fall back to the aligned lane.
  assign size_cur = norm_size(op_reg.size);
  assign lane_lo  = align_lane(size_cur, addr_reg[1:0]);

  load_align u_load_align (
    .rdata   (data_sram.rdata),
    .addr_lo (lane_lo),
    .size    (size_cur),
    .zext    (op_reg.zext),
    .data    (load_data)
  );

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = rdata_reg;
  assign resp_ale   = ale_reg;

  assign data_sram.req   = (state_reg == REQ);
  assign data_sram.wr    = op_reg.store;
  assign data_sram.size  = size_cur;
  assign data_sram.wstrb = op_reg.store ? store_strb(size_cur, lane_lo) : STRB_NONE;
  assign data_sram.addr  = addr_reg;
  assign data_sram.wdata = store_data(size_cur, wdata_reg);

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expectations, an SRAM
// responder checks bus requests and a response monitor checks results and latency.
module tb_mem_access_unit;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          aok;
    int          dok;
  } sram_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        ale;
    int          accept;
    int          lat;
    int          stall;
  } resp_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        sel;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;
  logic        sram_addr_ok, sram_data_ok;
  logic [31:0] sram_rdata;

  logic        a_req_ready, b_req_ready, a_resp_valid, b_resp_valid, a_resp_ale, b_resp_ale;
  logic [31:0] a_resp_rdata, b_resp_rdata;

  mem_access_unit_if sram_a ();
  mem_access_unit_if sram_b ();

  assign sram_a.addr_ok = sram_addr_ok;
  assign sram_a.data_ok = sram_data_ok;
  assign sram_a.rdata   = sram_rdata;
  assign sram_b.addr_ok = sram_addr_ok;
  assign sram_b.data_ok = sram_data_ok;
  assign sram_b.rdata   = sram_rdata;

  mem_access_unit #(.ALE_CHECK(1)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && !sel), .req_ready(a_req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready && !sel),
    .resp_rdata(a_resp_rdata), .resp_ale(a_resp_ale),
    .data_sram(sram_a)
  );

  mem_access_unit #(.ALE_CHECK(0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && sel), .req_ready(b_req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready && sel),
    .resp_rdata(b_resp_rdata), .resp_ale(b_resp_ale),
    .data_sram(sram_b)
  );

  logic        o_req_ready, o_resp_valid, o_resp_ale;
  logic [31:0] o_resp_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;

  assign o_req_ready  = sel ? b_req_ready  : a_req_ready;
  assign o_resp_valid = sel ? b_resp_valid : a_resp_valid;
  assign o_resp_ale   = sel ? b_resp_ale   : a_resp_ale;
  assign o_resp_rdata = sel ? b_resp_rdata : a_resp_rdata;
  assign s_req   = sel ? sram_b.req   : sram_a.req;
  assign s_wr    = sel ? sram_b.wr    : sram_a.wr;
  assign s_size  = sel ? sram_b.size  : sram_a.size;
  assign s_wstrb = sel ? sram_b.wstrb : sram_a.wstrb;
  assign s_addr  = sel ? sram_b.addr  : sram_a.addr;
  assign s_wdata = sel ? sram_b.wdata : sram_a.wdata;

  resp_exp_t rq[$];
  sram_exp_t sq[$];
  int checks = 0;
  int passes = 0;
  int last_hs_cyc = -10;
  int n_resp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // SRAM model: checks each request cycle against the queued expectation, raises
  // addr_ok after aok request cycles and data_ok dok cycles into WAIT.
  initial begin : responder
    logic        pend;
    int          wait_cnt, pend_dok, req_cnt;
    logic [31:0] pend_rdata;
    sram_exp_t   e;
    pend = 1'b0; wait_cnt = 0; pend_dok = 0; req_cnt = 0; pend_rdata = '0;
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = 32'h5A5A5A5A;
    forever begin
      @(negedge clk);
      sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = 32'h5A5A5A5A;
      if (reset) begin
        pend = 1'b0; req_cnt = 0;
      end else begin
        if (pend) begin
          if (wait_cnt == pend_dok) begin
            sram_data_ok = 1'b1; sram_rdata = pend_rdata; pend = 1'b0;
          end else wait_cnt++;
        end
        if (s_req) begin
          if (sq.size() == 0) begin
            checks++;
            $display("FAIL sram_unexpected_req: got req=1 addr=0x%08h, required no request (cycle %0d)", s_addr, cyc);
          end else begin
            e = sq[0];
            check("sram_ctrl", {s_wr, s_size, s_wstrb}, {e.wr, e.size, e.wstrb});
            check("sram_addr", s_addr, e.addr);
            check("sram_wdata", s_wdata, e.wdata);
            if (req_cnt == e.aok) begin
              sram_addr_ok = 1'b1; pend = 1'b1; wait_cnt = 0;
              pend_dok = e.dok; pend_rdata = e.rdata; req_cnt = 0;
              void'(sq.pop_front());
            end else req_cnt++;
          end
        end
      end
    end
  end

  // Response monitor: pops on each new resp_valid, applies the queued backpressure.
  initial begin : monitor
    logic      in_resp;
    int        stall_left;
    resp_exp_t cur;
    in_resp = 1'b0; stall_left = 0; resp_ready = 1'b0;
    cur = '{rdata: '0, ale: 1'b0, accept: 0, lat: 0, stall: 0};
    forever begin
      @(negedge clk);
      if (reset) begin
        in_resp = 1'b0; resp_ready = 1'b0;
      end else if (o_resp_valid) begin
        if (!in_resp) begin
          in_resp = 1'b1;
          if (rq.size() == 0) begin
            checks++;
            $display("FAIL resp_unexpected: got rdata=0x%08h ale=%0b, required no response (cycle %0d)",
                     o_resp_rdata, o_resp_ale, cyc);
            cur.rdata = o_resp_rdata; stall_left = 0;
          end else begin
            cur = rq.pop_front();
            n_resp++;
            check("resp_rdata", o_resp_rdata, cur.rdata);
            check("resp_ale", o_resp_ale, cur.ale);
            check("resp_latency", cyc - cur.accept, cur.lat);
            $display("resp %0d: rdata=0x%08h ale=%0b latency=%0d", n_resp, o_resp_rdata, o_resp_ale, cyc - cur.accept);
            stall_left = cur.stall;
          end
        end else begin
          check("resp_hold_rdata", o_resp_rdata, cur.rdata);
          check("resp_hold_req_ready", o_req_ready, 1'b0);
        end
        if (stall_left > 0) begin
          resp_ready = 1'b0; stall_left--;
        end else begin
          resp_ready = 1'b1; last_hs_cyc = cyc; in_resp = 1'b0;
        end
      end else resp_ready = 1'b0;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] sram_rd, input int aok, input int dok, input int stall,
                       input logic exp_ale, input logic [31:0] exp_rdata, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wdata, input bit want_resp);
    sram_exp_t se;
    resp_exp_t re;
    bit        waited;
    int        n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    waited = 1'b0; n = 0;
    while (!o_req_ready) begin
      waited = 1'b1;
      @(negedge clk);
      n++;
      if (n > 100) begin
        $display("FAIL accept_timeout: got req_ready=0 for %0d cycles, required acceptance", n);
        $fatal(1, "request never accepted");
      end
    end
    if (waited) check("accept_after_resp", cyc, last_hs_cyc + 1);
    if (!exp_ale) begin
      se.wr = op[3]; se.size = (op[1:0] == 2'd3) ? 2'd2 : op[1:0];
      se.wstrb = exp_strb; se.addr = addr; se.wdata = exp_wdata;
      se.rdata = sram_rd; se.aok = aok; se.dok = dok;
      sq.push_back(se);
    end
    if (want_resp) begin
      re.rdata = exp_rdata; re.ale = exp_ale; re.accept = cyc;
      re.lat = exp_ale ? 1 : 3 + aok + dok; re.stall = stall;
      rq.push_back(re);
    end
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rq.size() != 0 || !o_req_ready) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        $display("FAIL drain_timeout: got %0d responses pending, required 0", rq.size());
        $fatal(1, "responses never completed");
      end
    end
  endtask

  initial begin : stim
    int n;
    sel = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", a_req_ready, 1'b1);
    check("rst_req_ready_b", b_req_ready, 1'b1);
    check("rst_resp_valid", a_resp_valid, 1'b0);
    check("rst_resp_rdata", a_resp_rdata, 32'd0);
    check("rst_resp_ale", a_resp_ale, 1'b0);
    check("rst_sram_req", sram_a.req, 1'b0);
    check("rst_sram_ctrl", {sram_a.wr, sram_a.size, sram_a.wstrb}, 7'd0);
    check("rst_sram_addr", sram_a.addr, 32'd0);
    check("rst_sram_wdata", sram_a.wdata, 32'd0);
    reset = 1'b0;

    // Loads: word, byte signed/unsigned, half signed/unsigned, illegal size 3.
    issue(4'b0010, 32'h1c000004, 32'd0, 32'hDEADBEEF, 0, 0, 0, 1'b0, 32'hDEADBEEF, 4'h0, 32'd0, 1'b1);
    issue(4'b0000, 32'h1c000003, 32'd0, 32'h80123456, 0, 0, 0, 1'b0, 32'hFFFFFF80, 4'h0, 32'd0, 1'b1);
    issue(4'b0100, 32'h1c000003, 32'd0, 32'h80123456, 0, 0, 0, 1'b0, 32'h00000080, 4'h0, 32'd0, 1'b1);
    issue(4'b0001, 32'h1c000002, 32'd0, 32'h80011234, 0, 0, 0, 1'b0, 32'hFFFF8001, 4'h0, 32'd0, 1'b1);
    issue(4'b0101, 32'h1c000000, 32'd0, 32'h1234F00D, 0, 0, 0, 1'b0, 32'h0000F00D, 4'h0, 32'd0, 1'b1);
    issue(4'b0000, 32'h1c000001, 32'd0, 32'h00007F00, 0, 2, 0, 1'b0, 32'h0000007F, 4'h0, 32'd0, 1'b1);
    issue(4'b0011, 32'h1c000008, 32'd0, 32'h13579BDF, 0, 0, 0, 1'b0, 32'h13579BDF, 4'h0, 32'd0, 1'b1);

    // Stores: strobes and lane replication.
    issue(4'b1001, 32'h1c000102, 32'h0000ABCD, 32'h5555AAAA, 0, 0, 0, 1'b0, 32'd0, 4'b1100, 32'hABCDABCD, 1'b1);
    issue(4'b1000, 32'h1c000101, 32'h12345678, 32'h5555AAAA, 1, 0, 0, 1'b0, 32'd0, 4'b0010, 32'h78787878, 1'b1);
    issue(4'b1010, 32'h1c000100, 32'hCAFEF00D, 32'h5555AAAA, 0, 0, 0, 1'b0, 32'd0, 4'b1111, 32'hCAFEF00D, 1'b1);

    // Misaligned with the check enabled: immediate ALE response, no SRAM traffic.
    issue(4'b0010, 32'h1c000002, 32'd0, 32'd0, 0, 0, 0, 1'b1, 32'd0, 4'h0, 32'd0, 1'b1);
    issue(4'b0001, 32'h1c000001, 32'd0, 32'd0, 0, 0, 0, 1'b1, 32'd0, 4'h0, 32'd0, 1'b1);
    issue(4'b1010, 32'h1c000003, 32'h11111111, 32'd0, 0, 0, 1, 1'b1, 32'd0, 4'h0, 32'd0, 1'b1);
    issue(4'b1001, 32'h1c000001, 32'h22222222, 32'd0, 0, 0, 0, 1'b1, 32'd0, 4'h0, 32'd0, 1'b1);
    drain();

    // Same kind of addresses with the check disabled: forced-aligned lanes.
    sel = 1'b1;
    issue(4'b0010, 32'h1c000006, 32'd0, 32'h11223344, 0, 0, 0, 1'b0, 32'h11223344, 4'h0, 32'd0, 1'b1);
    issue(4'b0001, 32'h1c000001, 32'd0, 32'hAAAA8765, 0, 0, 0, 1'b0, 32'hFFFF8765, 4'h0, 32'd0, 1'b1);
    issue(4'b1001, 32'h1c000003, 32'h0000BEEF, 32'd0, 0, 0, 0, 1'b0, 32'd0, 4'b1100, 32'hBEEFBEEF, 1'b1);
    issue(4'b1010, 32'h1c000003, 32'h01020304, 32'd0, 0, 0, 0, 1'b0, 32'd0, 4'b1111, 32'h01020304, 1'b1);
    drain();
    sel = 1'b0;

    // Backpressure: slow addr_ok, stalled resp_ready, second request queued behind.
    issue(4'b0010, 32'h1c000010, 32'd0, 32'h0BADF00D, 5, 0, 3, 1'b0, 32'h0BADF00D, 4'h0, 32'd0, 1'b1);
    issue(4'b1010, 32'h1c000014, 32'h600DCAFE, 32'd0, 0, 1, 0, 1'b0, 32'd0, 4'b1111, 32'h600DCAFE, 1'b1);
    drain();

    // Reset while waiting for data_ok, then a store must run cleanly.
    issue(4'b0010, 32'h1c000300, 32'd0, 32'h77777777, 0, 8, 0, 1'b0, 32'd0, 4'h0, 32'd0, 1'b0);
    n = 0;
    while (s_req || o_req_ready || o_resp_valid) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        $display("FAIL wait_timeout: got no WAIT state, required one");
        $fatal(1, "WAIT never reached");
      end
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst_wait_req_ready", o_req_ready, 1'b1);
    check("rst_wait_resp_valid", o_resp_valid, 1'b0);
    check("rst_wait_sram_req", s_req, 1'b0);
    check("rst_wait_resp_rdata", o_resp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(4'b1000, 32'h1c000200, 32'h000000A5, 32'd0, 0, 0, 0, 1'b0, 32'd0, 4'b0001, 32'hA5A5A5A5, 1'b1);
    drain();
    check("sram_queue_empty", sq.size(), 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Multi-cycle load/store unit downstream of the EXE state of the multi-cycle core.
- Accepts one memory request at a time: effective address from ALU result, store data from rkd_value, access type from decode.
- Drives the data SRAM through a req/addr_ok/data_ok handshake.
- Returns aligned, extended load data, or store completion, to WB.
- Supports ld.b/ld.h/ld.w/ld.bu/ld.hu/st.b/st.h/st.w and flags misaligned addresses (ALE).

Parameters:
ALE_CHECK, 1, 1 = detect misaligned half/word accesses and skip SRAM; 0 = ignore low address bits (force aligned lane)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  core presents request
req_ready  output  1  unit can accept request (IDLE only)
req_op  input  4  [3]=store, [2]=unsigned (loads), [1:0]=size 0 byte/1 half/2 word
req_addr  input  32  effective address
req_wdata  input  32  store data (low bits significant)
resp_valid  output  1  result available
resp_ready  input  1  WB consumes result
resp_rdata  output  32  extended load data; 0 for stores/ALE
resp_ale  output  1  address-alignment error
data_sram_req  output  1  SRAM request
data_sram_wr  output  1  1 = write
data_sram_size  output  2  size code, as req_op[1:0]
data_sram_wstrb  output  4  byte strobes
data_sram_addr  output  32  address (word-aligned low bits kept as given)
data_sram_wdata  output  32  lane-replicated store data
data_sram_addr_ok  input  1  SRAM accepted request
data_sram_data_ok  input  1  read data valid / write done
data_sram_rdata  input  32  read data

Behaviour:
- FSM states IDLE, REQ, WAIT, RESP. Reset: state=IDLE; all outputs 0 except req_ready=1. Captured op/addr/wdata regs cleared.
- IDLE: req_ready=1.
  - On req_valid: capture op/addr/wdata.
  - If ALE_CHECK and misaligned (half: addr[0]!=0; word: addr[1:0]!=0): go to RESP with resp_ale=1, resp_rdata=0. No SRAM access.
  - Otherwise go to REQ.
- REQ: data_sram_req=1; addr/wr/size/wstrb/wdata held stable from the captured registers. On addr_ok, go to WAIT. req stays high until addr_ok.
- WAIT: data_sram_req=0. data_ok is sampled only in WAIT; data_ok seen in the same cycle as addr_ok in REQ is ignored by contract, because the SRAM never issues it there. On data_ok:
  - Load: register extracted data.
  - Store: resp_rdata=0.
  - Go to RESP.
- RESP: resp_valid=1 with registered rdata/ale held stable. On resp_ready, go to IDLE. No new request is accepted in the same cycle; req_ready is asserted the next cycle.
- Minimum latency, with addr_ok and data_ok asserted one cycle apart: accept at cycle 0, REQ at 1, WAIT at 2, resp_valid at cycle 3. ALE response: resp_valid at cycle 1.
- Strobes:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<{addr[1],1'b0}.
  - Word: 4'hF.
  - Loads: 4'h0.
- Store data replication:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: as is.
- Load extraction:
  - Byte lane = rdata[8*addr[1:0]+:8].
  - Half lane = rdata[16*addr[1]+:16].
  - Sign-extend unless req_op[2]=1, which zero-extends. Word passes through.
- size code 3 is illegal: treated as word.
- reset in any state returns to IDLE on the next edge and drops data_sram_req. The SRAM shares reset, so no stale data_ok arrives.
- req_valid while not IDLE: ignored (req_ready=0).

Decomposition:
- Shared package mem_pkg:
  - mem_op field positions.
  - Size codes SZ_B=0, SZ_H=1, SZ_W=2.
  - FSM state encodings (2 bits).
  - Strobe/replication helper constants.
- One combinational sub-module, load_align: inputs rdata, addr[1:0], size, unsigned; output extended 32-bit data. It is reused later by any cache refill path.

Test Plan:
1. ld.w addr 0x1c000004, SRAM returns 0xDEADBEEF, addr_ok at cycle 1, data_ok at cycle 2 -> resp_valid at cycle 3, resp_rdata=0xDEADBEEF, wstrb=0, ale=0.
2. ld.b addr offset 3, rdata=0x80123456 -> rdata=0xFFFFFF80; same request with ld.bu -> 0x00000080; ld.h offset 2 with rdata 0x8001xxxx -> 0xFFFF8001.
3. st.h addr offset 2, wdata=0x0000ABCD -> SRAM wr=1, wstrb=4'b1100, wdata=0xABCDABCD; resp_valid with rdata=0 after data_ok.
4. ld.w addr 0x...02 with ALE_CHECK=1 -> no data_sram_req ever, resp_valid at cycle 1, resp_ale=1. With ALE_CHECK=0 -> normal access, wstrb/extraction use forced-aligned lane.
5. Backpressure: addr_ok delayed 5 cycles and resp_ready held low 3 cycles -> req and address stay stable throughout, resp_rdata stays stable, req_ready=0 until the cycle after the handshake, a second req_valid meanwhile is not accepted.
6. reset asserted during WAIT -> next cycle state IDLE, req_ready=1, resp_valid=0, data_sram_req=0; a following st.b executes correctly.
